candy_avb_gpio: RTL and testbench

Parametrised Avalon-MM general-purpose I/O block for the CANDY_AVB Qsys system. It succeeds the fixed 2-bit output-only PIO and provides:
- configurable width and per-bit direction;
- atomic set/clear of output bits;
- synchronised inputs with edge capture;
- a maskable level interrupt to the Nios II IRQ input.

It sits on the system Avalon-MM interconnect as a zero-wait-state slave.

---
 rtl/candy_avb_gpio_pkg.sv | 15 +
 rtl/candy_avb_gpio_if.sv | 20 ++
 rtl/candy_avb_gpio_sync.sv | 32 +++
 rtl/candy_avb_gpio.sv | 129 ++++++++++++
 tb/tb_candy_avb_gpio.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/candy_avb_gpio_pkg.sv
// rtl/candy_avb_gpio_pkg.sv - register map and edge-type encodings for candy_avb_gpio
package candy_avb_gpio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/candy_avb_gpio_if.sv
// rtl/candy_avb_gpio_if.sv - Avalon-MM slave bus bundle for the gpio register file
interface candy_avb_gpio_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/candy_avb_gpio_sync.sv
// rtl/candy_avb_gpio_sync.sv - WIDTH-wide, STAGES-deep pin synchroniser with async reset to 0
module candy_avb_gpio_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;
    logic [STAGES-1:0][WIDTH-1:0] stage_d;

    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/candy_avb_gpio.sv
// rtl/candy_avb_gpio.sv - Avalon-MM GPIO: direction, atomic set/clear, edge capture, masked irq
module candy_avb_gpio
    import candy_avb_gpio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] DATA_RESET  = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '0,
    parameter int               EDGE_TYPE   = EDGE_RISE,
    parameter int               SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    candy_avb_gpio_if.slave     bus,
    input  logic [WIDTH-1:0]    in_port,
    output logic [WIDTH-1:0]    out_port,
    output logic [WIDTH-1:0]    oe,
    output logic                irq
);

    localparam logic [2:0] ARM_LAST = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [2:0]       arm_cnt_q, arm_cnt_d;
    logic             irq_q, irq_d;

    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] cap_set;
    logic             wr_en;
    logic             armed;
    logic [31:0]      rdata;

    candy_avb_gpio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (in_port),
        .dout    (sync_in)
    );

    if (WIDTH < 32) begin : g_wdata_hi
        logic unused_wdata_hi;
        assign unused_wdata_hi = ^bus.writedata[31:WIDTH];
    end

    assign wr_en = bus.chipselect & ~bus.write_n;
    assign wdata = bus.writedata[WIDTH-1:0];
    assign armed = (arm_cnt_q == ARM_LAST);

    always_comb begin
        edge_hit = '0;
        if (EDGE_TYPE == EDGE_FALL) begin
            edge_hit = ~sync_in & prev_q;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            edge_hit = sync_in ^ prev_q;
        end else begin
            edge_hit = sync_in & ~prev_q;
        end
    end

    always_comb begin
        out_d     = out_q;
        dir_d     = dir_q;
        mask_d    = mask_q;
        w1c       = '0;
        prev_d    = sync_in;
        arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + 3'd1;
        if (wr_en) begin
            case (bus.address)
                ADDR_DATA:    out_d  = wdata;
                ADDR_DIR:     dir_d  = wdata;
                ADDR_IRQMASK: mask_d = wdata;
                ADDR_EDGECAP: w1c    = wdata;
                ADDR_OUTSET:  out_d  = out_q | wdata;
                ADDR_OUTCLR:  out_d  = out_q & ~wdata;
                default:      ;
            endcase
        end
        // Set is ORed in after the clear so a same-cycle edge is never lost.
        cap_set = edge_hit & ~dir_q & {WIDTH{armed}};
        cap_d   = (cap_q & ~w1c) | cap_set;
        irq_d   = |(cap_q & mask_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q     <= DATA_RESET;
            dir_q     <= DIR_RESET;
            mask_q    <= '0;
            cap_q     <= '0;
            prev_q    <= '0;
            arm_cnt_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            out_q     <= out_d;
            dir_q     <= dir_d;
            mask_q    <= mask_d;
            cap_q     <= cap_d;
            prev_q    <= prev_d;
            arm_cnt_q <= arm_cnt_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (bus.address)
            ADDR_DATA:    rdata[WIDTH-1:0] = (out_q & dir_q) | (sync_in & ~dir_q);
            ADDR_DIR:     rdata[WIDTH-1:0] = dir_q;
            ADDR_IRQMASK: rdata[WIDTH-1:0] = mask_q;
            ADDR_EDGECAP: rdata[WIDTH-1:0] = cap_q;
            default:      rdata = '0;
        endcase
    end

    assign bus.readdata = rdata;
    assign out_port     = out_q;
    assign oe           = dir_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_candy_avb_gpio.sv
// tb/tb_candy_avb_gpio.sv - directed scoreboard bench for candy_avb_gpio
module tb_candy_avb_gpio;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] in_port;
    logic [7:0] out_port;
    logic [7:0] oe;
    logic       irq;

    int checks = 0;
    int passed = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    candy_avb_gpio_if bus();

    candy_avb_gpio #(
        .WIDTH       (8),
        .DATA_RESET  (8'hA5),
        .DIR_RESET   (8'h0F),
        .EDGE_TYPE   (0),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .in_port  (in_port),
        .out_port (out_port),
        .oe       (oe),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_val(input string tag, input logic [31:0] val);
        tag_q.push_back(tag);
        exp_q.push_back(val);
    endtask

    task automatic compare(input logic [31:0] obs);
        string       tag;
        logic [31:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            tag = tag_q.pop_front();
            exp = exp_q.pop_front();
            assert (obs === exp) passed++;
            else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_read(input logic [2:0] addr, input string tag, input logic [31:0] val);
        expect_val(tag, val);
        bus.address = addr;
        #1;
        compare(bus.readdata);
    endtask

    task automatic check_sig(input logic [31:0] obs, input string tag, input logic [31:0] val);
        expect_val(tag, val);
        compare(obs);
    endtask

    task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
        bus.address    = addr;
        bus.writedata  = data;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    initial begin
        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'h0;
        in_port        = 8'hFF;
        reset_n        = 1'b0;
        #23;

        // Reset state, pins held high through reset
        check_sig(32'(out_port), "rst_out_port", 32'hA5);
        check_sig(32'(oe), "rst_oe", 32'h0F);
        check_sig(32'(irq), "rst_irq", 32'h0);
        check_read(3'd0, "rst_data", 32'h05);
        check_read(3'd1, "rst_dir", 32'h0F);
        check_read(3'd2, "rst_irqmask", 32'h0);
        check_read(3'd3, "rst_edgecap", 32'h0);
        check_read(3'd4, "rst_outset", 32'h0);
        check_read(3'd5, "rst_outclr", 32'h0);
        check_read(3'd6, "rst_addr6", 32'h0);
        check_read(3'd7, "rst_addr7", 32'h0);

        tick();
        reset_n = 1'b1;
        tick(6);
        check_read(3'd0, "arm_data_merge", 32'hF5);
        check_read(3'd3, "arm_no_false_edge", 32'h0);

        // Set/clear
        bus.address    = 3'd0;
        bus.writedata  = 32'h0;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        #1;
        check_sig(32'(out_port), "data_wr_before_edge", 32'hA5);
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        check_sig(32'(out_port), "data_wr_00", 32'h00);
        bus_write(3'd4, 32'hFFFF_FF81);
        check_sig(32'(out_port), "outset_81", 32'h81);
        bus_write(3'd5, 32'h01);
        check_sig(32'(out_port), "outclr_80", 32'h80);
        check_read(3'd4, "outset_reads0", 32'h0);
        check_read(3'd5, "outclr_reads0", 32'h0);

        // Rising-edge capture and irq
        bus_write(3'd1, 32'h00);
        check_sig(32'(oe), "dir_00", 32'h00);
        bus_write(3'd2, 32'h04);
        in_port = 8'h00;
        tick(5);
        check_read(3'd3, "fall_not_captured", 32'h0);
        check_read(3'd0, "data_input_low", 32'h00);
        in_port = 8'h04;
        tick(2);
        check_read(3'd3, "cap_not_yet", 32'h0);
        tick();
        check_read(3'd3, "cap_bit2", 32'h04);
        check_sig(32'(irq), "irq_not_yet", 32'h0);
        tick();
        check_sig(32'(irq), "irq_high", 32'h1);
        bus_write(3'd3, 32'h04);
        check_read(3'd3, "w1c_cleared", 32'h0);
        tick();
        check_sig(32'(irq), "irq_low_after_w1c", 32'h0);

        // Set-wins collision on bit 3
        in_port = 8'h0C;
        tick(2);
        bus_write(3'd3, 32'h08);
        check_read(3'd3, "collision_set_wins", 32'h08);
        tick();
        check_sig(32'(irq), "masked_no_irq", 32'h0);
        bus_write(3'd3, 32'h08);
        check_read(3'd3, "w1c_bit3", 32'h0);

        // Output-direction bits never capture
        bus_write(3'd1, 32'hFF);
        in_port = 8'h00;
        tick(4);
        in_port = 8'hFF;
        tick(4);
        in_port = 8'h00;
        tick(4);
        check_read(3'd3, "dir_out_ignored", 32'h0);
        check_read(3'd0, "data_dir_out", 32'h80);

        // Build up irq, then reset asynchronously mid-cycle
        bus_write(3'd1, 32'h00);
        bus_write(3'd2, 32'h01);
        in_port = 8'h01;
        tick(5);
        check_sig(32'(irq), "irq_before_reset", 32'h1);
        in_port = 8'hFF;
        #2;
        reset_n = 1'b0;
        #1;
        check_sig(32'(out_port), "async_rst_out", 32'hA5);
        check_sig(32'(oe), "async_rst_oe", 32'h0F);
        check_sig(32'(irq), "async_rst_irq", 32'h0);
        check_read(3'd3, "async_rst_edgecap", 32'h0);
        check_read(3'd2, "async_rst_irqmask", 32'h0);

        // Arming after mid-run reset, then a genuine edge on bit 0
        tick();
        reset_n = 1'b1;
        tick(6);
        check_read(3'd3, "rearm_no_false_edge", 32'h0);
        bus_write(3'd1, 32'h00);
        in_port = 8'hFE;
        tick(4);
        check_read(3'd3, "bit0_fall_ignored", 32'h0);
        in_port = 8'hFF;
        tick(3);
        check_read(3'd3, "bit0_rise_captured", 32'h01);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
